hack_data_memory_io: RTL and testbench

//  Data-side memory stage directly downstream of the Hack CPU core.
//  - Consumes the CPU's addressM/writeM/outM and returns inM.
//  - Decodes the 15-bit space into data RAM, screen RAM, keyboard register and status register.
//  - Forwards every screen write to an external display controller through a buffered valid/ready stream.

---
 rtl/hack_mem_pkg.sv | 37 +++
 rtl/hack_sync_fifo.sv | 59 +++++
 rtl/hack_data_memory_io.sv | 107 ++++++++++
 tb/tb_hack_data_memory_io.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/hack_mem_pkg.sv
// Shared address map, region decode and screen-write entry type for the Hack data memory stage.
package hack_mem_pkg;

    localparam logic [14:0] SCREEN_BASE = 15'h4000;
    localparam logic [14:0] KBD_ADDR    = 15'h6000;
    localparam logic [14:0] STATUS_ADDR = 15'h6001;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_SCREEN,
        REG_KBD,
        REG_STATUS,
        REG_NONE
    } region_e;

    typedef struct packed {
        logic [12:0] addr;
        logic [15:0] data;
    } scr_wr_t;

    // RAM is the lower half, SCREEN the next 8K; only two words above that are mapped.
    function automatic region_e decode_region(input logic [14:0] addr);
        region_e r;
        if (!addr[14])
            r = REG_RAM;
        else if (addr[14:13] == SCREEN_BASE[14:13])
            r = REG_SCREEN;
        else if (addr == KBD_ADDR)
            r = REG_KBD;
        else if (addr == STATUS_ADDR)
            r = REG_STATUS;
        else
            r = REG_NONE;
        return r;
    endfunction

endpackage

// File: rtl/hack_sync_fifo.sv
// Single-clock valid/ready FIFO with occupancy output; a push is accepted when full only if a pop
// happens in the same cycle.
module hack_sync_fifo #(
    parameter int WIDTH = 29,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [AW:0]      o_level
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_pop;
    logic             w_push_ok;

    assign o_full    = (r_level == FULL_LVL);
    assign o_valid   = (r_level != '0);
    assign o_data    = r_mem[r_rd_ptr];
    assign o_level   = r_level;
    assign w_pop     = o_valid && i_ready;
    assign w_push_ok = i_push && (!o_full || w_pop);

    // Storage is not reset; only pointers and level define which words are live.
    always_ff @(posedge clock) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/hack_data_memory_io.sv
// Hack CPU data-side memory stage: RAM/SCREEN/KBD/STATUS decode with combinational read-back and a
// buffered stream of screen writes towards the display controller.
module hack_data_memory_io
    import hack_mem_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [14:0] addressM,
    input  logic        writeM,
    input  logic [15:0] outM,
    output logic [15:0] inM,
    input  logic        kbd_valid,
    input  logic [15:0] kbd_code,
    output logic        kbd_ready,
    output logic        disp_valid,
    input  logic        disp_ready,
    output logic [12:0] disp_addr,
    output logic [15:0] disp_data,
    output logic        fifo_ovf
);

    logic [15:0]      r_ram    [16384];
    logic [15:0]      r_screen [8192];
    logic [15:0]      r_kbd;
    logic             r_ovf;

    region_e          w_region;
    logic             w_ram_wr;
    logic             w_scr_wr;
    logic             w_stat_wr;
    logic             w_fifo_full;
    logic             w_pop;
    logic [FIFO_AW:0] w_level;
    logic [3:0]       w_level4;
    scr_wr_t          w_push_entry;
    scr_wr_t          w_head;

    assign w_region  = decode_region(addressM);
    assign w_ram_wr  = writeM && (w_region == REG_RAM);
    assign w_scr_wr  = writeM && (w_region == REG_SCREEN);
    assign w_stat_wr = writeM && (w_region == REG_STATUS);

    assign w_push_entry.addr = addressM[12:0];
    assign w_push_entry.data = outM;

    hack_sync_fifo #(
        .WIDTH ($bits(scr_wr_t)),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_scr_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .i_push  (w_scr_wr),
        .i_data  (w_push_entry),
        .o_full  (w_fifo_full),
        .o_valid (disp_valid),
        .i_ready (disp_ready),
        .o_data  (w_head),
        .o_level (w_level)
    );

    assign w_pop     = disp_valid && disp_ready;
    assign disp_addr = w_head.addr;
    assign disp_data = w_head.data;
    assign fifo_ovf  = r_ovf;
    assign kbd_ready = reset_n;
    assign w_level4  = 4'(w_level);

    always_ff @(posedge clock) begin
        if (w_ram_wr)
            r_ram[addressM[13:0]] <= outM;
        if (w_scr_wr)
            r_screen[addressM[12:0]] <= outM;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_kbd <= '0;
        else if (kbd_valid)
            r_kbd <= kbd_code;
    end

    // A dropped push outranks a same-cycle STATUS write so no overflow is ever lost.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_ovf <= 1'b0;
        else if (w_scr_wr && w_fifo_full && !w_pop)
            r_ovf <= 1'b1;
        else if (w_stat_wr)
            r_ovf <= 1'b0;
    end

    always_comb begin
        inM = '0;
        case (w_region)
            REG_RAM:    inM = r_ram[addressM[13:0]];
            REG_SCREEN: inM = r_screen[addressM[12:0]];
            REG_KBD:    inM = r_kbd;
            REG_STATUS: inM = {r_ovf, 11'b0, w_level4};
            default:    inM = '0;
        endcase
    end

endmodule

// File: tb/tb_hack_data_memory_io.sv
// Directed bench for hack_data_memory_io: scoreboard queue of expected display-stream entries,
// plus a small occupancy/overflow model for STATUS.
module tb_hack_data_memory_io;
    import hack_mem_pkg::*;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [14:0] addressM;
    logic        writeM;
    logic [15:0] outM;
    logic [15:0] inM;
    logic        kbd_valid;
    logic [15:0] kbd_code;
    logic        kbd_ready;
    logic        disp_valid;
    logic        disp_ready;
    logic [12:0] disp_addr;
    logic [15:0] disp_data;
    logic        fifo_ovf;

    int      total = 0;
    int      bad   = 0;
    scr_wr_t q[$];
    logic    m_ovf = 1'b0;

    hack_data_memory_io #(.FIFO_DEPTH(8), .FIFO_AW(3)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .addressM   (addressM),
        .writeM     (writeM),
        .outM       (outM),
        .inM        (inM),
        .kbd_valid  (kbd_valid),
        .kbd_code   (kbd_code),
        .kbd_ready  (kbd_ready),
        .disp_valid (disp_valid),
        .disp_ready (disp_ready),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .fifo_ovf   (fifo_ovf)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] status_exp();
        return {m_ovf, 11'b0, 4'(q.size())};
    endfunction

    // Compare any handshake that will happen at the coming edge, then advance one cycle.
    task automatic tick();
        scr_wr_t e;
        if (disp_valid === 1'b1 && disp_ready === 1'b1) begin
            check("pop_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("pop_addr", 32'(disp_addr), 32'(e.addr));
                check("pop_data", 32'(disp_data), 32'(e.data));
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic read_chk(input string tag, input logic [14:0] a, input logic [15:0] exp);
        addressM = a;
        writeM   = 1'b0;
        #1;
        check(tag, 32'(inM), 32'(exp));
    endtask

    task automatic mem_write(input logic [14:0] a, input logic [15:0] d);
        addressM = a;
        outM     = d;
        writeM   = 1'b1;
        tick();
        writeM   = 1'b0;
    endtask

    task automatic scr_write(input logic [14:0] a, input logic [15:0] d);
        scr_wr_t e;
        e.addr = a[12:0];
        e.data = d;
        if (q.size() < DEPTH || (q.size() != 0 && disp_ready))
            q.push_back(e);
        else
            m_ovf = 1'b1;
        mem_write(a, d);
    endtask

    initial begin
        reset_n    = 1'b0;
        addressM   = '0;
        writeM     = 1'b0;
        outM       = '0;
        kbd_valid  = 1'b0;
        kbd_code   = '0;
        disp_ready = 1'b0;
        tick();
        tick();
        check("rst_kbd_ready", 32'(kbd_ready), 32'd0);
        check("rst_disp_valid", 32'(disp_valid), 32'd0);
        reset_n = 1'b1;
        tick();
        check("kbd_ready_after_rst", 32'(kbd_ready), 32'd1);
        check("disp_valid_after_rst", 32'(disp_valid), 32'd0);
        read_chk("kbd_after_rst", 15'h6000, 16'h0000);
        read_chk("status_after_rst", 15'h6001, status_exp());

        // RAM write/read, KBD and unmapped writes ignored
        mem_write(15'h0010, 16'h1234);
        read_chk("ram_0010", 15'h0010, 16'h1234);
        mem_write(15'h3FFF, 16'hC0DE);
        read_chk("ram_3fff", 15'h3FFF, 16'hC0DE);
        read_chk("ram_0010_again", 15'h0010, 16'h1234);
        mem_write(15'h6000, 16'hBEEF);
        read_chk("kbd_write_ignored", 15'h6000, 16'h0000);
        mem_write(15'h7000, 16'h5555);
        read_chk("unmapped_read", 15'h7000, 16'h0000);

        // Single screen write: no fall-through, visible next cycle, popped with ready high
        disp_ready = 1'b1;
        check("no_fallthrough_pre", 32'(disp_valid), 32'd0);
        scr_write(15'h4005, 16'hFFFF);
        check("single_valid", 32'(disp_valid), 32'd1);
        check("single_addr", 32'(disp_addr), 32'h5);
        check("single_data", 32'(disp_data), 32'hFFFF);
        tick();
        check("single_drained", 32'(disp_valid), 32'd0);
        read_chk("single_status", 15'h6001, status_exp());
        read_chk("screen_4005", 15'h4005, 16'hFFFF);

        // Overflow: nine writes into an eight-deep FIFO with no consumer
        disp_ready = 1'b0;
        for (int i = 0; i < 9; i++)
            scr_write(15'h4000 + 15'(i), 16'h0100 + 16'(i));
        check("ovf_flag", 32'(fifo_ovf), 32'(m_ovf));
        check("ovf_flag_set", 32'(fifo_ovf), 32'd1);
        read_chk("ovf_status", 15'h6001, status_exp());
        read_chk("ovf_status_8008", 15'h6001, 16'h8008);
        read_chk("screen_9th", 15'h4008, 16'h0108);
        check("head_stable_addr", 32'(disp_addr), 32'h0);
        check("head_stable_data", 32'(disp_data), 32'h0100);
        mem_write(15'h6001, 16'h0000);
        m_ovf = 1'b0;
        read_chk("status_cleared", 15'h6001, 16'h0008);
        check("ovf_cleared", 32'(fifo_ovf), 32'd0);

        // Full FIFO with a push and a pop in the same cycle
        disp_ready = 1'b1;
        scr_write(15'h400A, 16'hAAAA);
        check("full_pushpop_ovf", 32'(fifo_ovf), 32'd0);
        read_chk("full_pushpop_status", 15'h6001, status_exp());
        for (int i = 0; i < 20 && q.size() != 0; i++)
            tick();
        check("drain_done", 32'(q.size()), 32'd0);
        check("drain_valid", 32'(disp_valid), 32'd0);
        read_chk("drain_status", 15'h6001, 16'h0000);

        // Keyboard capture and hold
        kbd_valid = 1'b1;
        kbd_code  = 16'h0041;
        tick();
        kbd_valid = 1'b0;
        kbd_code  = 16'h0099;
        read_chk("kbd_0041", 15'h6000, 16'h0041);
        tick();
        read_chk("kbd_hold", 15'h6000, 16'h0041);
        kbd_valid = 1'b1;
        kbd_code  = 16'h0000;
        tick();
        kbd_valid = 1'b0;
        read_chk("kbd_zero", 15'h6000, 16'h0000);
        read_chk("unmapped_6100", 15'h6100, 16'h0000);

        // Asynchronous reset while entries are pending
        disp_ready = 1'b0;
        scr_write(15'h4100, 16'h1111);
        scr_write(15'h4101, 16'h2222);
        kbd_valid = 1'b1;
        kbd_code  = 16'h0077;
        tick();
        kbd_valid = 1'b0;
        check("pending_valid", 32'(disp_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        q.delete();
        m_ovf = 1'b0;
        check("async_rst_valid", 32'(disp_valid), 32'd0);
        check("async_rst_kbd_ready", 32'(kbd_ready), 32'd0);
        read_chk("async_rst_kbd", 15'h6000, 16'h0000);
        read_chk("async_rst_status", 15'h6001, status_exp());
        tick();
        reset_n = 1'b1;
        tick();
        read_chk("screen_survives_rst", 15'h4101, 16'h2222);
        read_chk("ram_survives_rst", 15'h0010, 16'h1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
